// File: rtl/bridge_pkg.sv
// Shared definitions for the host-bridge receive path: ASCII codes, message
// lengths, parser states and the decoded request record.
package bridge_pkg;

    localparam logic [7:0] CHAR_R  = 8'h52;
    localparam logic [7:0] CHAR_W  = 8'h57;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    // Hex digits per message body: 4 for reads (addr), 8 for writes (addr+data)
    localparam logic [3:0] READ_LEN  = 4'd4;
    localparam logic [3:0] WRITE_LEN = 4'd8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        ERROR = 2'd3
    } state_e;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
        logic        rw;
    } bus_req_t;

    function automatic logic is_eol(input logic [7:0] b);
        return (b == CHAR_CR) || (b == CHAR_LF);
    endfunction

endpackage

// File: rtl/bridge_rx_if.sv
// Byte-in / request-out signal bundle of the bridge receive parser.
interface bridge_rx_if;
    logic [7:0]  data_i;
    logic        valid_i;
    logic [15:0] addr_o;
    logic [15:0] data_o;
    logic        rw_o;
    logic        valid_o;

    modport slave (
        input  data_i, valid_i,
        output addr_o, data_o, rw_o, valid_o
    );

    modport master (
        output data_i, valid_i,
        input  addr_o, data_o, rw_o, valid_o
    );
endinterface

// File: rtl/bridge_rx_hex_decode.sv
// ASCII hex digit decoder: returns the nibble value and whether the byte is a
// hex digit at all (either letter case accepted).
module hex_decode (
    input  logic [7:0] i_byte,
    output logic [3:0] o_nibble,
    output logic       o_is_hex
);
    always_comb begin
        o_nibble = 4'h0;
        o_is_hex = 1'b0;
        if (i_byte >= 8'h30 && i_byte <= 8'h39) begin
            o_nibble = i_byte[3:0];
            o_is_hex = 1'b1;
        end else if ((i_byte >= 8'h41 && i_byte <= 8'h46) ||
                     (i_byte >= 8'h61 && i_byte <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so value = low nibble + 9
            o_nibble = i_byte[3:0] + 4'd9;
            o_is_hex = 1'b1;
        end
    end
endmodule

// File: rtl/bridge_rx.sv
// Receive-side parser: turns "Raaaa<EOL>" / "Waaaadddd<EOL>" byte streams into
// single-cycle bus requests; malformed lines are dropped up to the next EOL.
module bridge_rx
    import bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    bridge_rx_if.slave  bus
);
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_READ  = READ;
    localparam logic [1:0] ST_WRITE = WRITE;
    localparam logic [1:0] ST_ERROR = ERROR;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [15:0] r_addr_sh;
    logic [15:0] r_data_sh;
    bus_req_t    r_req;
    logic        r_valid;

    logic [3:0]  w_nib;
    logic        w_is_hex;
    logic        w_eol;

    hex_decode u_hex (
        .i_byte   (bus.data_i),
        .o_nibble (w_nib),
        .o_is_hex (w_is_hex)
    );

    assign w_eol = is_eol(bus.data_i);

    always_ff @(posedge clk) begin
        r_valid <= 1'b0;
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_addr_sh <= 16'h0;
            r_data_sh <= 16'h0;
            r_req     <= '0;
        end else if (bus.valid_i) begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= 4'd0;
                    if (bus.data_i == CHAR_R)      r_state <= ST_READ;
                    else if (bus.data_i == CHAR_W) r_state <= ST_WRITE;
                    else if (!w_eol)               r_state <= ST_ERROR;
                end
                ST_READ: begin
                    if (w_eol) begin
                        if (r_cnt == READ_LEN) begin
                            r_req   <= '{addr: r_addr_sh, data: 16'h0, rw: 1'b0};
                            r_valid <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end else if (w_is_hex && r_cnt < READ_LEN) begin
                        r_addr_sh <= {r_addr_sh[11:0], w_nib};
                        r_cnt     <= r_cnt + 4'd1;
                    end else begin
                        r_state <= ST_ERROR;
                    end
                end
                ST_WRITE: begin
                    if (w_eol) begin
                        if (r_cnt == WRITE_LEN) begin
                            r_req   <= '{addr: r_addr_sh, data: r_data_sh, rw: 1'b1};
                            r_valid <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end else if (w_is_hex && r_cnt < WRITE_LEN) begin
                        // First four digits form the address, the rest the data
                        if (r_cnt < READ_LEN) r_addr_sh <= {r_addr_sh[11:0], w_nib};
                        else                  r_data_sh <= {r_data_sh[11:0], w_nib};
                        r_cnt <= r_cnt + 4'd1;
                    end else begin
                        r_state <= ST_ERROR;
                    end
                end
                ST_ERROR: begin
                    if (w_eol) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.addr_o  = r_req.addr;
    assign bus.data_o  = r_req.data;
    assign bus.rw_o    = r_req.rw;
    assign bus.valid_o = r_valid;

endmodule

// File: tb/tb_bridge_rx.sv
// Self-checking bench for bridge_rx: directed message table plus random byte
// streams checked against a line-level reference model.
module tb_bridge_rx;
    import bridge_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bridge_rx_if bus();
    bridge_rx dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        string       msg;
        int          pulses;
        logic [15:0] addr;
        logic [15:0] data;
        logic        rw;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int pulses;
    bit gaps_on = 1'b1;

    // Reference model: buffer the current line, judge it whole at EOL
    logic [15:0]       m_addr, m_data;
    logic              m_rw, m_vld;
    byte unsigned      line_q[$];

    function automatic int hexval(input byte unsigned c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        return -1;
    endfunction

    task automatic model_line();
        int len = 0;
        bit ok;
        logic [31:0] v = 32'h0;
        if (line_q.size() == 0) return;
        if (line_q[0] == 8'h52) len = 5;
        if (line_q[0] == 8'h57) len = 9;
        ok = (len != 0) && (line_q.size() == len);
        for (int i = 1; i < line_q.size(); i++)
            if (hexval(line_q[i]) < 0) ok = 1'b0;
        if (!ok) return;
        for (int i = 1; i < len; i++) v = (v << 4) | 32'(hexval(line_q[i]));
        m_vld = 1'b1;
        if (len == 5) begin
            m_addr = v[15:0]; m_data = 16'h0; m_rw = 1'b0;
        end else begin
            m_addr = v[31:16]; m_data = v[15:0]; m_rw = 1'b1;
        end
    endtask

    task automatic model_byte(input byte unsigned b);
        m_vld = 1'b0;
        if (b == 8'h0D || b == 8'h0A) begin
            model_line();
            line_q.delete();
        end else begin
            line_q.push_back(b);
        end
    endtask

    task automatic check(input string name);
        n_vec++;
        if (bus.valid_o !== m_vld || bus.addr_o !== m_addr ||
            bus.data_o !== m_data || bus.rw_o !== m_rw) begin
            n_err++;
            $display("FAIL %s: got vld=%0b addr=%h data=%h rw=%0b, want vld=%0b addr=%h data=%h rw=%0b",
                     name, bus.valid_o, bus.addr_o, bus.data_o, bus.rw_o,
                     m_vld, m_addr, m_data, m_rw);
        end
    endtask

    task automatic send(input byte unsigned b);
        int g;
        bus.data_i  = b;
        bus.valid_i = 1'b1;
        @(posedge clk); #1;
        model_byte(b);
        if (bus.valid_o === 1'b1) pulses++;
        check("byte");
        bus.valid_i = 1'b0;
        g = gaps_on ? $urandom_range(0, 2) : 0;
        repeat (g) begin
            bus.data_i = 8'($urandom);
            @(posedge clk); #1;
            m_vld = 1'b0;
            check("gap");
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        bus.valid_i = 1'b1;
        bus.data_i  = 8'h57;
        @(posedge clk); #1;
        line_q.delete();
        m_addr = 16'h0; m_data = 16'h0; m_rw = 1'b0; m_vld = 1'b0;
        check("reset");
        rst_n       = 1'b1;
        bus.valid_i = 1'b0;
    endtask

    task automatic check_msg(input string name, input vec_t v);
        n_vec++;
        if (pulses != v.pulses || bus.addr_o !== v.addr ||
            bus.data_o !== v.data || bus.rw_o !== v.rw) begin
            n_err++;
            $display("FAIL %s: got pulses=%0d addr=%h data=%h rw=%0b, want pulses=%0d addr=%h data=%h rw=%0b",
                     name, pulses, bus.addr_o, bus.data_o, bus.rw_o,
                     v.pulses, v.addr, v.data, v.rw);
        end
    endtask

    function automatic vec_t mk(input string m, input int p, input logic [15:0] a,
                                input logic [15:0] d, input logic r);
        vec_t v;
        v.msg = m; v.pulses = p; v.addr = a; v.data = d; v.rw = r;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        string hx;
        string junk;
        int    kind, nd;
        hx   = "0123456789abcdefABCDEF";
        junk = "RW0123456789aFGxrw #\r\n";

        tbl.push_back(mk("W12345678\r\n",      1, 16'h1234, 16'h5678, 1'b1));
        tbl.push_back(mk("WDEADBEEF\r\n",      1, 16'hDEAD, 16'hBEEF, 1'b1));
        tbl.push_back(mk("RBABE\r\n",          1, 16'hBABE, 16'h0000, 1'b0));
        tbl.push_back(mk("R0000\r",            1, 16'h0000, 16'h0000, 1'b0));
        tbl.push_back(mk("WF00DBEEF\r",        1, 16'hF00D, 16'hBEEF, 1'b1));
        tbl.push_back(mk("WB0BACAFE\n",        1, 16'hB0BA, 16'hCAFE, 1'b1));
        tbl.push_back(mk("RABC\r\n",           0, 16'hB0BA, 16'hCAFE, 1'b1));
        tbl.push_back(mk("R1234\r",            1, 16'h1234, 16'h0000, 1'b0));
        tbl.push_back(mk("WABC\r\n",           0, 16'h1234, 16'h0000, 1'b0));
        tbl.push_back(mk("R\r\n",              0, 16'h1234, 16'h0000, 1'b0));
        tbl.push_back(mk("WFFFF1111\n",        1, 16'hFFFF, 16'h1111, 1'b1));
        tbl.push_back(mk("R12345\r\n",         0, 16'hFFFF, 16'h1111, 1'b1));
        tbl.push_back(mk("R1234\r",            1, 16'h1234, 16'h0000, 1'b0));
        tbl.push_back(mk("W123456789101112131415161718191201222\r\n",
                                               0, 16'h1234, 16'h0000, 1'b0));
        tbl.push_back(mk("RABCG\r\n",          0, 16'h1234, 16'h0000, 1'b0));
        tbl.push_back(mk("WABC[]()##*@\r\n",   0, 16'h1234, 16'h0000, 1'b0));
        tbl.push_back(mk("X1234\r\n",          0, 16'h1234, 16'h0000, 1'b0));
        tbl.push_back(mk("R5a5A\n",            1, 16'h5A5A, 16'h0000, 1'b0));
        tbl.push_back(mk("rABCD\n",            0, 16'h5A5A, 16'h0000, 1'b0));
        tbl.push_back(mk("wFFFF0000\n",        0, 16'h5A5A, 16'h0000, 1'b0));
        tbl.push_back(mk("W0000ffff\n",        1, 16'h0000, 16'hFFFF, 1'b1));

        bus.data_i  = 8'h00;
        bus.valid_i = 1'b0;
        rst_n       = 1'b0;
        @(posedge clk);
        do_reset();

        foreach (tbl[i]) begin
            pulses = 0;
            send_str(tbl[i].msg);
            check_msg($sformatf("tbl[%0d]", i), tbl[i]);
        end

        // Abort mid-message, then a clean write through input gaps
        send_str("W12");
        do_reset();
        pulses = 0;
        send_str("W00010002\n");
        check_msg("reset_recover", mk("", 1, 16'h0001, 16'h0002, 1'b1));

        // Random lines: well-formed, near-miss and junk, random EOL flavours
        for (int n = 0; n < 250; n++) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0, 1: begin send(8'h52); repeat (4) send(hx[$urandom_range(0, 21)]); end
                2, 3: begin send(8'h57); repeat (8) send(hx[$urandom_range(0, 21)]); end
                4: begin
                    nd = $urandom_range(0, 10);
                    repeat (nd) send(junk[$urandom_range(0, junk.len() - 1)]);
                end
                default: begin
                    send(($urandom_range(0, 1) != 0) ? 8'h52 : 8'h57);
                    nd = $urandom_range(0, 9);
                    repeat (nd) send(hx[$urandom_range(0, 21)]);
                end
            endcase
            if ($urandom_range(0, 29) == 0) do_reset();
            case ($urandom_range(0, 3))
                0: send(8'h0D);
                1: send(8'h0A);
                2: begin send(8'h0D); send(8'h0A); end
                default: begin send(8'h0A); send(8'h0D); end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
